// File: rtl/adc_fill_burst_sequencer.sv
// rtl/adc_fill_burst_sequencer.sv - per-fill ADC burst acquisition sequencer
// Latches a fill size from the external mux, then gates ADC bursts into the fill buffer.
module adc_fill_burst_sequencer #(
    parameter int BURST_W = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               trigger,
    input  logic [1:0]         fill_type_in,
    input  logic [BURST_W-1:0] num_fill_bursts,
    input  logic               adc_burst_valid,
    input  logic               fill_abort,
    output logic [1:0]         fill_type,
    output logic               size_latch,
    output logic               burst_we,
    output logic [BURST_W-1:0] burst_addr,
    output logic               busy,
    output logic               fill_done,
    output logic [BURST_W-1:0] fill_bursts_written,
    output logic               fill_aborted,
    output logic               trig_overlap
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        LOAD  = 3'd2,
        ACQ   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [BURST_W-1:0] counter;
    logic [BURST_W-1:0] target;
    logic               accept;
    logic               write;
    logic               last;
    logic               aborting;
    logic               entering_done;

    always_comb begin
        accept        = (state == IDLE) && trigger;
        write         = adc_burst_valid && (state == ACQ);
        last          = write && (counter == target - 1'b1);
        aborting      = fill_abort && ((state == LATCH) || (state == LOAD) || (state == ACQ));
        state_next    = state;
        case (state)
            IDLE:    if (trigger) state_next = LATCH;
            LATCH:   state_next = aborting ? DONE : LOAD;
            LOAD:    state_next = (aborting || (num_fill_bursts == '0)) ? DONE : ACQ;
            ACQ:     if (aborting || last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        entering_done = (state != DONE) && (state_next == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            fill_type           <= 2'b00;
            counter             <= '0;
            target              <= '0;
            fill_bursts_written <= '0;
            fill_aborted        <= 1'b0;
            trig_overlap        <= 1'b0;
        end else begin
            state        <= state_next;
            trig_overlap <= trigger && (state != IDLE);
            if (state == LOAD) target <= num_fill_bursts;
            if (accept) begin
                fill_type    <= fill_type_in;
                counter      <= '0;
                fill_aborted <= 1'b0;
            end else if (write) begin
                counter <= counter + 1'b1;
            end
            // A burst written alongside the abort still counts toward the reported total.
            if (entering_done) begin
                fill_bursts_written <= write ? counter + 1'b1 : counter;
                fill_aborted        <= aborting;
            end
        end
    end

    assign size_latch = (state == LATCH);
    assign busy       = (state != IDLE);
    assign fill_done  = (state == DONE);
    assign burst_we   = write;
    assign burst_addr = counter;

endmodule

// File: tb/tb_adc_fill_burst_sequencer.sv
// tb/tb_adc_fill_burst_sequencer.sv - scoreboard bench for adc_fill_burst_sequencer
module tb_adc_fill_burst_sequencer;
    localparam int W = 24;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         trigger = 1'b0;
    logic [1:0]   fill_type_in = 2'b00;
    logic [W-1:0] num_fill_bursts = '0;
    logic         adc_burst_valid = 1'b0;
    logic         fill_abort = 1'b0;
    logic [1:0]   fill_type;
    logic         size_latch;
    logic         burst_we;
    logic [W-1:0] burst_addr;
    logic         busy;
    logic         fill_done;
    logic [W-1:0] fill_bursts_written;
    logic         fill_aborted;
    logic         trig_overlap;

    int total = 0;
    int bad = 0;
    int addr_q[$];
    int done_n_q[$];
    int done_ab_q[$];
    logic [W-1:0] cnt_tab [4];

    adc_fill_burst_sequencer #(.BURST_W(W)) dut (
        .clk(clk), .reset(reset), .trigger(trigger), .fill_type_in(fill_type_in),
        .num_fill_bursts(num_fill_bursts), .adc_burst_valid(adc_burst_valid),
        .fill_abort(fill_abort), .fill_type(fill_type), .size_latch(size_latch),
        .burst_we(burst_we), .burst_addr(burst_addr), .busy(busy), .fill_done(fill_done),
        .fill_bursts_written(fill_bursts_written), .fill_aborted(fill_aborted),
        .trig_overlap(trig_overlap)
    );

    always #5 clk = ~clk;

    // fill-size mux: registers the count for the latched type while size_latch is high
    always @(posedge clk) begin
        if (size_latch) num_fill_bursts <= cnt_tab[fill_type];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (burst_we) begin
                if (addr_q.size() == 0) check_eq("unexp_we", 32'(burst_we), 32'd0);
                else check_eq("burst_addr", 32'(burst_addr), 32'(addr_q.pop_front()));
            end
            if (fill_done) begin
                if (done_n_q.size() == 0) begin
                    check_eq("unexp_done", 32'(fill_done), 32'd0);
                end else begin
                    check_eq("bursts_written", 32'(fill_bursts_written), 32'(done_n_q.pop_front()));
                    check_eq("fill_aborted", 32'(fill_aborted), 32'(done_ab_q.pop_front()));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_done(input int n, input int ab);
        done_n_q.push_back(n);
        done_ab_q.push_back(ab);
    endtask

    task automatic start_fill(input logic [1:0] t);
        trigger = 1'b1;
        fill_type_in = t;
        step();
        trigger = 1'b0;
        check_eq("size_latch", 32'(size_latch), 32'd1);
        check_eq("fill_type", 32'(fill_type), 32'(t));
    endtask

    task automatic burst(input int idx);
        adc_burst_valid = 1'b1;
        addr_q.push_back(idx);
        step();
        adc_burst_valid = 1'b0;
    endtask

    initial begin
        cnt_tab[0] = 24'd0;
        cnt_tab[1] = 24'd5;
        cnt_tab[2] = 24'd3;
        cnt_tab[3] = 24'd100;
        repeat (3) step();
        reset = 1'b0;
        step();

        check_eq("rst_fill_type", 32'(fill_type), 32'd0);
        check_eq("rst_size_latch", 32'(size_latch), 32'd0);
        check_eq("rst_fill_done", 32'(fill_done), 32'd0);
        check_eq("rst_aborted", 32'(fill_aborted), 32'd0);
        check_eq("rst_overlap", 32'(trig_overlap), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_written", 32'(fill_bursts_written), 32'd0);
        check_eq("rst_we", 32'(burst_we), 32'd0);
        check_eq("rst_addr", 32'(burst_addr), 32'd0);

        // normal 5-burst fill
        expect_done(5, 0);
        start_fill(2'b01);
        step();
        step();
        for (int i = 0; i < 5; i++) burst(i);
        check_eq("norm_done", 32'(fill_done), 32'd1);
        step();
        check_eq("norm_idle", 32'(busy), 32'd0);
        check_eq("norm_held", 32'(fill_bursts_written), 32'd5);

        // zero-size fill
        expect_done(0, 0);
        start_fill(2'b00);
        step();
        check_eq("zero_t2_done", 32'(fill_done), 32'd0);
        step();
        check_eq("zero_t3_done", 32'(fill_done), 32'd1);
        step();
        check_eq("zero_t4_busy", 32'(busy), 32'd0);

        // gaps and dropped valids
        expect_done(3, 0);
        start_fill(2'b10);
        adc_burst_valid = 1'b1;
        check_eq("drop_latch_we", 32'(burst_we), 32'd0);
        step();
        check_eq("drop_load_we", 32'(burst_we), 32'd0);
        step();
        adc_burst_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(1, 6)) step();
            burst(i);
        end
        adc_burst_valid = 1'b1;
        check_eq("drop_done_we", 32'(burst_we), 32'd0);
        step();
        check_eq("drop_idle_we", 32'(burst_we), 32'd0);
        step();
        adc_burst_valid = 1'b0;
        check_eq("drop_counter", 32'(burst_addr), 32'd3);

        // abort together with the 10th valid of a 100-burst fill
        expect_done(10, 1);
        start_fill(2'b11);
        step();
        step();
        for (int i = 0; i < 9; i++) burst(i);
        fill_abort = 1'b1;
        burst(9);
        fill_abort = 1'b0;
        check_eq("abort_done", 32'(fill_done), 32'd1);
        step();
        fill_abort = 1'b1;
        step();
        fill_abort = 1'b0;
        check_eq("abort_idle_ign", 32'(busy), 32'd0);

        // abort while still in LATCH
        expect_done(0, 1);
        start_fill(2'b01);
        fill_abort = 1'b1;
        step();
        fill_abort = 1'b0;
        check_eq("abort_latch_done", 32'(fill_done), 32'd1);
        step();

        // trigger during ACQ and during DONE
        expect_done(5, 0);
        start_fill(2'b01);
        step();
        step();
        burst(0);
        burst(1);
        trigger = 1'b1;
        burst(2);
        trigger = 1'b0;
        check_eq("ovl_acq_pulse", 32'(trig_overlap), 32'd1);
        check_eq("ovl_acq_busy", 32'(busy), 32'd1);
        burst(3);
        check_eq("ovl_pulse_end", 32'(trig_overlap), 32'd0);
        burst(4);
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        check_eq("ovl_done_pulse", 32'(trig_overlap), 32'd1);
        check_eq("ovl_done_ignored", 32'(busy), 32'd0);
        step();

        // reset in the middle of ACQ
        start_fill(2'b11);
        step();
        step();
        for (int i = 0; i < 3; i++) burst(i);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_addr", 32'(burst_addr), 32'd0);
        step();
        reset = 1'b0;
        step();
        expect_done(3, 0);
        start_fill(2'b10);
        step();
        step();
        for (int i = 0; i < 3; i++) burst(i);
        repeat (3) step();

        check_eq("addr_q_empty", 32'(addr_q.size()), 32'd0);
        check_eq("done_q_empty", 32'(done_n_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/adc_fill_burst_sequencer.md
# adc_fill_burst_sequencer

Per-fill acquisition sequencer on the channel ADC path. It consumes the burst count produced by the fill-size mux. On an accepted trigger it strobes the mux enable, loads the selected burst count for the fill type, and gates incoming 8-sample ADC bursts into the fill buffer with a running burst address. It flags fill completion and reports how many bursts were written.

## Interface
Parameters:
- BURST_W, 24, width of burst counts and burst address.

Ports:
- clk  input  1  system clock; every register updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- trigger  input  1  single-cycle request to start a fill.
- fill_type_in  input  2  fill type, sampled together with an accepted trigger.
- num_fill_bursts  input  BURST_W  registered output of the fill-size mux.
- adc_burst_valid  input  1  one-cycle pulse per completed 8-sample ADC burst.
- fill_abort  input  1  ends an in-progress fill early.
- fill_type  output  2  latched fill type; drives the mux select.
- size_latch  output  1  drives the mux enable.
- burst_we  output  1  fill-buffer write strobe.
- burst_addr  output  BURST_W  burst index for the current write.
- busy  output  1  high in every state except IDLE.
- fill_done  output  1  one-cycle pulse at fill end.
- fill_bursts_written  output  BURST_W  bursts written in the last fill; valid while fill_done is high and held until the next fill_done.
- fill_aborted  output  1  qualifies fill_done; set when the fill ended by abort.
- trig_overlap  output  1  one-cycle pulse when a trigger is ignored.

## Operation
State machine: IDLE, LATCH, LOAD, ACQ, DONE. All outputs are Moore/registered except burst_we and burst_addr, as noted below.

- **IDLE**
  - When trigger=1: capture fill_type_in into fill_type, clear the burst counter, go to LATCH.
- **LATCH**
  - size_latch=1 for exactly this cycle; the mux registers its output at the end of this cycle.
  - Go to LOAD.
- **LOAD**
  - Capture num_fill_bursts into the target register.
  - If the value is 0 (fill type 00, or a zero-configured count), go to DONE.
  - Otherwise go to ACQ.
- **ACQ**
  - burst_we = adc_burst_valid & (state==ACQ). This is combinational.
  - burst_addr = burst counter, so writes are indexed from 0.
  - On each valid, the counter increments.
  - On the valid where counter == target-1, go to DONE.
- **DONE**
  - fill_done=1 for one cycle.
  - fill_bursts_written = counter value after the final increment.
  - Return to IDLE.
- **fill_abort**
  - In LATCH, LOAD or ACQ: go to DONE next cycle with fill_aborted=1. The counter holds the bursts written so far.
  - An adc_burst_valid in the same cycle as the abort is still written and counted.
  - In IDLE or DONE: fill_abort is ignored.
- **trigger while busy**
  - The trigger is ignored and trig_overlap pulses the next cycle.
  - A trigger arriving in the DONE cycle is also ignored; the earliest accepted retrigger is the first IDLE cycle.
- **adc_burst_valid outside ACQ**
  - Dropped: burst_we stays 0 and the counter does not move.
- **Counter width**
  - The counter never exceeds the target, so it cannot wrap. A target of 2^24-1 is legal.

Reset values: state=IDLE, fill_type=00, size_latch=0, fill_done=0, fill_aborted=0, trig_overlap=0, busy=0, fill_bursts_written=0, counter=0, target=0. burst_we=0 because the state is IDLE.

Reset mid-fill: all state clears immediately, no fill_done is produced, and the fill in progress is lost.

## Timing
- Trigger accepted at cycle T:
  - LATCH at T+1.
  - LOAD at T+2.
  - ACQ from T+3; T+3 is the first cycle in which a burst can be written.
- Zero-size fill: DONE at T+3, fill_done pulses at T+3, and busy falls at T+4.
- Final valid at cycle F: DONE, and the fill_done pulse, at F+1; IDLE at F+2.
- Throughput: one burst per cycle (adc_burst_valid high back-to-back is supported).
- Minimum trigger-to-trigger spacing: N+4 cycles for an N-burst fill, assuming back-to-back bursts.

## Test plan
- **Reset check:** assert reset, release it, send no stimulus. Every output must sit at its reset value.
- **Normal fill:** fill_type_in=01, mux count=5, trigger, then 5 back-to-back valids from T+3.
  - Required: burst_we on 5 cycles with burst_addr 0,1,2,3,4.
  - fill_done one cycle after the last valid, with fill_bursts_written=5 and fill_aborted=0.
- **Zero-size fill:** fill_type_in=00 (mux count=0), trigger.
  - Required: size_latch at T+1, fill_done at T+3, fill_bursts_written=0, and no burst_we.
- **Gaps and dropped valids:** count=3, valids spaced 2–7 cycles apart, plus extra valids in LATCH, LOAD and after DONE.
  - Required: only 3 writes (addresses 0–2); the extra valids are ignored.
- **Abort:** count=100, abort in the same cycle as the 10th valid.
  - Required: 10 writes, fill_done next cycle with fill_aborted=1 and fill_bursts_written=10.
- **Overlap and mid-fill reset:**
  - Trigger during ACQ → trig_overlap pulse and the fill continues unchanged.
  - Assert reset mid-ACQ → immediate IDLE, no fill_done, and the next fill starts at burst_addr 0.
